// File: rtl/xb_cmd_sequencer_if.sv
// Host/application bundle for xb_cmd_sequencer: host-write FIFO head,
// host-read FIFO write port, application stream and run controls.
interface xb_cmd_sequencer_if;
    logic        pc_msg_valid;
    logic [31:0] pc_msg;
    logic        pc_msg_ack;
    logic        fpga_msg_full;
    logic        fpga_msg_valid;
    logic [31:0] fpga_msg;
    logic        data_valid;
    logic [31:0] data;
    logic        data_ack;
    logic        app_done;
    logic        run;
    logic [15:0] run_len;
    logic [31:0] run_cfg;
    logic [31:0] run_gain;
    logic        msg_error;

    modport slave (
        input  pc_msg_valid, pc_msg, fpga_msg_full,
        input  data_valid, data, app_done,
        output pc_msg_ack, fpga_msg_valid, fpga_msg, data_ack,
        output run, run_len, run_cfg, run_gain, msg_error
    );

    modport master (
        output pc_msg_valid, pc_msg, fpga_msg_full,
        output data_valid, data, app_done,
        input  pc_msg_ack, fpga_msg_valid, fpga_msg, data_ack,
        input  run, run_len, run_cfg, run_gain, msg_error
    );
endinterface

// File: rtl/xb_cmd_sequencer.sv
// Assembles 3-word host commands into run controls and arbitrates the
// host-read FIFO between queued status reports and application data.
module xb_cmd_sequencer #(
    parameter int XB_SIZE = 32,
    parameter int TIMEOUT = 1023
) (
    input logic               CLK,
    input logic               RESET,
    xb_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {W0, W1, W2, EXEC} state_e;
    localparam int GW = $clog2(TIMEOUT + 1);

    state_e             state_q;
    logic [XB_SIZE-1:0] w0_q, w1_q, w2_q;
    logic [GW-1:0]      gap_q;
    logic               run_q, err_q, fvalid_q;
    logic [15:0]        len_q;
    logic [31:0]        cfg_q, gain_q, fmsg_q;
    logic [23:0]        sq_q [4];
    logic [1:0]         rptr_q, wptr_q;
    logic [2:0]         cnt_q;

    logic        ack, dack, pop, room, is_stop, is_start;
    logic        exec_go, gap_cnt, tmo, done_ev, psr_ev, load;
    logic        run_d;
    logic [7:0]  code;
    logic [23:0] psr_ent, slot0;
    logic [1:0]  npush;

    // Parser work may enqueue alongside app_done, so it needs two free slots.
    assign room     = cnt_q <= 3'd2;
    assign pop      = !bus.fpga_msg_full && cnt_q != 3'd0;
    assign dack     = !bus.fpga_msg_full && cnt_q == 3'd0
                      && run_q && bus.data_valid;
    assign ack      = bus.pc_msg_valid && state_q != EXEC && !RESET;
    assign is_stop  = w0_q == '0 && w1_q == '0 && w2_q == '0;
    assign is_start = w0_q[31:16] == 16'd0 && w0_q[15:0] != 16'd0;
    assign exec_go  = state_q == EXEC && room;
    assign gap_cnt  = (state_q == W1 || state_q == W2)
                      && !bus.pc_msg_valid && room;
    assign tmo      = gap_cnt && gap_q == GW'(TIMEOUT - 1);
    assign done_ev  = bus.app_done && run_q;
    assign psr_ev   = exec_go || tmo;
    assign load     = exec_go && is_start && !run_q;
    assign npush    = {1'b0, done_ev} + {1'b0, psr_ev};

    always_comb begin
        code = 8'h0F;
        unique case (1'b1)
            is_stop:  code = 8'h02;
            is_start: code = run_q ? 8'h0E : 8'h01;
            default:  ;
        endcase
        if (tmo) code = 8'h0D;
    end

    assign psr_ent = {code, tmo ? 16'd0 : w0_q[15:0]};
    assign slot0   = done_ev ? {8'h03, len_q} : psr_ent;

    always_comb begin
        run_d = run_q;
        if (done_ev || (exec_go && is_stop)) run_d = 1'b0;
        else if (load)                       run_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= W0;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            gap_q    <= '0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
            fvalid_q <= 1'b0;
            len_q    <= '0;
            cfg_q    <= '0;
            gain_q   <= '0;
            fmsg_q   <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) sq_q[i] <= '0;
        end else begin
            if (npush != 2'd0) sq_q[wptr_q] <= slot0;
            if (npush == 2'd2) sq_q[wptr_q + 2'd1] <= psr_ent;
            wptr_q <= wptr_q + npush;
            rptr_q <= rptr_q + {1'b0, pop};
            cnt_q  <= cnt_q + {1'b0, npush} - {2'b0, pop};

            fvalid_q <= pop || dack;
            if (pop)       fmsg_q <= {8'hA5, sq_q[rptr_q]};
            else if (dack) fmsg_q <= bus.data;

            unique case (state_q)
                W0: if (ack) begin
                    w0_q    <= bus.pc_msg;
                    state_q <= W1;
                end
                W1: if (ack) begin
                    w1_q    <= bus.pc_msg;
                    state_q <= W2;
                end else if (tmo) state_q <= W0;
                W2: if (ack) begin
                    w2_q    <= bus.pc_msg;
                    state_q <= EXEC;
                end else if (tmo) state_q <= W0;
                EXEC: if (room) state_q <= W0;
            endcase

            if (ack || tmo)   gap_q <= '0;
            else if (gap_cnt) gap_q <= gap_q + GW'(1);

            run_q <= run_d;
            if (load) begin
                len_q  <= w0_q[15:0];
                cfg_q  <= w1_q;
                gain_q <= w2_q;
            end
            if (tmo || (exec_go && !is_stop && !is_start)) err_q <= 1'b1;
        end
    end

    assign bus.pc_msg_ack     = ack;
    assign bus.data_ack       = dack;
    assign bus.fpga_msg_valid = fvalid_q;
    assign bus.fpga_msg       = fmsg_q;
    assign bus.run            = run_q;
    assign bus.run_len        = len_q;
    assign bus.run_cfg        = cfg_q;
    assign bus.run_gain       = gain_q;
    assign bus.msg_error      = err_q;

endmodule
